// File: rtl/day08_pair_scheduler_if.sv
// Point-load, run-control and pair-beat signals shared by the day-8 pair scheduler
// (master) and whoever loads points and consumes beats (slave).
interface day08_pair_scheduler_if #(
  parameter int MAX_NODE_COUNT  = 2000,
  parameter int COORD_BIT_WIDTH = 12,
  parameter int DIMENSIONS      = 3,
  parameter int BATCH_SIZE      = 16
);
  localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT);

  logic                       load_valid;
  logic [COORD_BIT_WIDTH-1:0] load_coord [0:DIMENSIONS-1];
  logic                       load_ready;

  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       count_error;
  logic [INDEX_BIT_WIDTH:0]   node_count;

  logic                       out_ready;
  logic [COORD_BIT_WIDTH-1:0] batch_coords [0:BATCH_SIZE-1][0:DIMENSIONS-1];
  logic [INDEX_BIT_WIDTH-1:0] batch_indices [0:BATCH_SIZE-1];
  logic [BATCH_SIZE-1:0]      batch_valid;
  logic                       batch_line_end;
  logic                       batch_stream_end;

  modport master (
    input  load_valid, load_coord, start, out_ready,
    output load_ready, busy, done, count_error, node_count,
           batch_coords, batch_indices, batch_valid, batch_line_end, batch_stream_end
  );

  modport slave (
    output load_valid, load_coord, start, out_ready,
    input  load_ready, busy, done, count_error, node_count,
           batch_coords, batch_indices, batch_valid, batch_line_end, batch_stream_end
  );
endinterface

// File: rtl/day08_pair_scheduler.sv
// Stores the day-8 point list and streams every unordered pair (i, j>i) as
// BATCH_SIZE-wide beats, one reference line at a time, with lane 0 = reference point.
module day08_pair_scheduler #(
  parameter int MAX_NODE_COUNT  = 2000,
  parameter int COORD_BIT_WIDTH = 12,
  parameter int DIMENSIONS      = 3,
  parameter int BATCH_SIZE      = 16
) (
  input logic                    clk,
  input logic                    rst,
  day08_pair_scheduler_if.master bus
);
  localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT);
  localparam int CW              = INDEX_BIT_WIDTH + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] W_BATCH = CW'(BATCH_SIZE);
  localparam logic [CW-1:0] W_MAX   = CW'(MAX_NODE_COUNT);

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j0;
  logic          r_reload;
  logic          r_loadReady;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic [COORD_BIT_WIDTH-1:0] r_mem [0:MAX_NODE_COUNT-1][0:DIMENSIONS-1];

  logic [COORD_BIT_WIDTH-1:0] r_coords  [0:BATCH_SIZE-1][0:DIMENSIONS-1];
  logic [INDEX_BIT_WIDTH-1:0] r_indices [0:BATCH_SIZE-1];
  logic [BATCH_SIZE-1:0]      r_valid;
  logic                       r_lineEnd;
  logic                       r_streamEnd;

  logic          w_loadFire;
  logic          w_startOk;
  logic          w_startBad;
  logic          w_accept;
  logic [CW-1:0] w_writeAddr;
  logic [CW-1:0] w_countAfterLoad;
  logic [CW-1:0] w_idleCount;
  logic          w_idleReady;
  logic [CW-1:0] w_selI;
  logic [CW-1:0] w_selJ0;

  logic [CW-1:0]              w_lane    [0:BATCH_SIZE-1];
  logic [COORD_BIT_WIDTH-1:0] w_coords  [0:BATCH_SIZE-1][0:DIMENSIONS-1];
  logic [INDEX_BIT_WIDTH-1:0] w_indices [0:BATCH_SIZE-1];
  logic [BATCH_SIZE-1:0]      w_valid;
  logic                       w_lineEnd;
  logic                       w_streamEnd;

  // A start takes precedence over a load presented in the same cycle; that load is dropped.
  always_comb begin
    w_loadFire       = (r_state == S_IDLE) && bus.load_valid && r_loadReady && !bus.start;
    w_startOk        = (r_state == S_IDLE) && bus.start && (r_count >= CW'(2));
    w_startBad       = (r_state == S_IDLE) && bus.start && (r_count < CW'(2));
    w_accept         = (r_state == S_EMIT) && (|r_valid) && bus.out_ready;
    w_writeAddr      = r_reload ? '0 : r_count;
    w_countAfterLoad = w_writeAddr + CW'(1);
    w_idleCount      = w_loadFire ? w_countAfterLoad : w_writeAddr;
    w_idleReady      = (w_idleCount < W_MAX);
  end

  // Pointer of the beat to register next: (0,0) on start, otherwise successor of the shown beat.
  always_comb begin
    w_selI  = '0;
    w_selJ0 = '0;
    if (r_state == S_EMIT) begin
      if (!r_lineEnd) begin
        w_selI  = r_i;
        w_selJ0 = r_j0 + W_BATCH;
      end else begin
        w_selI  = r_i + CW'(1);
        w_selJ0 = r_i + CW'(1);
      end
    end
  end

  always_comb begin
    w_lineEnd   = ((w_selJ0 + W_BATCH) >= r_count);
    w_streamEnd = w_lineEnd && (w_selI == (r_count - CW'(2)));
    w_valid     = '0;
    for (int k = 0; k < BATCH_SIZE; k++) begin
      w_lane[k]    = w_selJ0 + CW'(k);
      w_indices[k] = '0;
      for (int d = 0; d < DIMENSIONS; d++) begin
        w_coords[k][d] = '0;
      end
      if (w_lane[k] < r_count) begin
        w_valid[k]   = 1'b1;
        w_indices[k] = w_lane[k][INDEX_BIT_WIDTH-1:0];
        for (int d = 0; d < DIMENSIONS; d++) begin
          w_coords[k][d] = r_mem[w_lane[k][INDEX_BIT_WIDTH-1:0]][d];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_loadFire && !rst) begin
      for (int d = 0; d < DIMENSIONS; d++) begin
        r_mem[w_writeAddr[INDEX_BIT_WIDTH-1:0]][d] <= bus.load_coord[d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_i         <= '0;
      r_j0        <= '0;
      r_reload    <= 1'b0;
      r_loadReady <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_loadReady <= w_idleReady;
          if (w_startOk) begin
            r_state     <= S_EMIT;
            r_busy      <= 1'b1;
            r_loadReady <= 1'b0;
            r_i         <= w_selI;
            r_j0        <= w_selJ0;
          end else if (w_startBad) begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
          end else if (w_loadFire) begin
            r_count  <= w_countAfterLoad;
            r_reload <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            if (r_streamEnd) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_i  <= w_selI;
              r_j0 <= w_selJ0;
            end
          end
        end
        S_DONE: begin
          // Points stay stored for a re-run; the next load restarts the list at entry 0.
          r_state     <= S_IDLE;
          r_reload    <= 1'b1;
          r_loadReady <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (w_accept && r_streamEnd)) begin
      r_valid     <= '0;
      r_lineEnd   <= 1'b0;
      r_streamEnd <= 1'b0;
      for (int k = 0; k < BATCH_SIZE; k++) begin
        r_indices[k] <= '0;
        for (int d = 0; d < DIMENSIONS; d++) begin
          r_coords[k][d] <= '0;
        end
      end
    end else if (w_startOk || w_accept) begin
      r_valid     <= w_valid;
      r_lineEnd   <= w_lineEnd;
      r_streamEnd <= w_streamEnd;
      r_indices   <= w_indices;
      r_coords    <= w_coords;
    end
  end

  assign bus.load_ready       = r_loadReady;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.count_error      = r_err;
  assign bus.node_count       = r_count;
  assign bus.batch_coords     = r_coords;
  assign bus.batch_indices    = r_indices;
  assign bus.batch_valid      = r_valid;
  assign bus.batch_line_end   = r_lineEnd;
  assign bus.batch_stream_end = r_streamEnd;
endmodule

// File: tb/tb_day08_pair_scheduler.sv
// Bench for day08_pair_scheduler: a small B=4 instance for the pair stream and a
// MAX=40, B=16 instance for full storage, both checked against a nested-loop pair model.
module tb_day08_pair_scheduler;
  localparam int C     = 12;
  localparam int D     = 3;
  localparam int A_MAX = 16;
  localparam int A_B   = 4;
  localparam int A_IW  = $clog2(A_MAX);
  localparam int B_MAX = 40;
  localparam int B_B   = 16;
  localparam int B_IW  = $clog2(B_MAX);

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  day08_pair_scheduler_if #(.MAX_NODE_COUNT(A_MAX), .COORD_BIT_WIDTH(C), .DIMENSIONS(D), .BATCH_SIZE(A_B)) busA ();
  day08_pair_scheduler_if #(.MAX_NODE_COUNT(B_MAX), .COORD_BIT_WIDTH(C), .DIMENSIONS(D), .BATCH_SIZE(B_B)) busB ();

  day08_pair_scheduler #(.MAX_NODE_COUNT(A_MAX), .COORD_BIT_WIDTH(C), .DIMENSIONS(D), .BATCH_SIZE(A_B)) dutA (
    .clk(clk), .rst(rstA), .bus(busA)
  );
  day08_pair_scheduler #(.MAX_NODE_COUNT(B_MAX), .COORD_BIT_WIDTH(C), .DIMENSIONS(D), .BATCH_SIZE(B_B)) dutB (
    .clk(clk), .rst(rstB), .bus(busB)
  );

  // Reference model: stored points, count, and the pair-line walk as (i, j0) queues.
  int mA [0:A_MAX-1][0:D-1];
  int nA;
  bit reloadA;
  int mB [0:B_MAX-1][0:D-1];
  int qI [$];
  int qJ [$];

  logic [A_B-1:0]        expValA, obsValA;
  logic [A_B*A_IW-1:0]   expIdxA, obsIdxA;
  logic [A_B*D*C-1:0]    expCrdA, obsCrdA;
  logic                  expLeA, obsLeA, expSeA, obsSeA;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic void build_expected(input int n, input int bsz);
    qI.delete();
    qJ.delete();
    for (int i = 0; i <= n - 2; i++) begin
      for (int j0 = i; j0 < n; j0 += bsz) begin
        qI.push_back(i);
        qJ.push_back(j0);
      end
    end
  endfunction

  function automatic void expect_beat_a(input int i, input int j0, input int n);
    expValA = '0;
    expIdxA = '0;
    expCrdA = '0;
    for (int k = 0; k < A_B; k++) begin
      if (j0 + k < n) begin
        expValA[k] = 1'b1;
        expIdxA[k*A_IW +: A_IW] = A_IW'(j0 + k);
        for (int d = 0; d < D; d++) expCrdA[(k*D+d)*C +: C] = C'(mA[j0+k][d]);
      end
    end
    expLeA = (j0 + A_B >= n);
    expSeA = expLeA && (i == n - 2);
  endfunction

  function automatic void observe_a();
    obsValA = busA.batch_valid;
    for (int k = 0; k < A_B; k++) begin
      obsIdxA[k*A_IW +: A_IW] = busA.batch_indices[k];
      for (int d = 0; d < D; d++) obsCrdA[(k*D+d)*C +: C] = busA.batch_coords[k][d];
    end
    obsLeA = busA.batch_line_end;
    obsSeA = busA.batch_stream_end;
  endfunction

  task automatic load_a();
    if (reloadA) begin
      nA      = 0;
      reloadA = 1'b0;
    end
    busA.load_valid = 1'b1;
    for (int d = 0; d < D; d++) begin
      mA[nA][d]          = int'($urandom_range(0, (1 << C) - 1));
      busA.load_coord[d] = C'(mA[nA][d]);
    end
    nA++;
    cycle();
    busA.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstA = 1'b1;
    rstB = 1'b1;
    busA.load_valid = 1'b0; busA.start = 1'b0; busA.out_ready = 1'b0;
    busB.load_valid = 1'b0; busB.start = 1'b0; busB.out_ready = 1'b0;
    for (int d = 0; d < D; d++) begin
      busA.load_coord[d] = '0;
      busB.load_coord[d] = '0;
    end
    repeat (2) cycle();
    total++;
    if ({busA.batch_valid, busA.batch_line_end, busA.batch_stream_end} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_batch: got v=%b le=%b se=%b want all 0", busA.batch_valid, busA.batch_line_end, busA.batch_stream_end);
    end
    total++;
    if ({busA.busy, busA.done, busA.count_error, busA.load_ready} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got busy/done/err/ready=%b%b%b%b want 0000", busA.busy, busA.done, busA.count_error, busA.load_ready);
    end
    total++;
    if (busA.node_count !== '0 || busB.node_count !== '0) begin
      bad++;
      $display("[TB] FAIL reset_count: got %0d/%0d want 0/0", busA.node_count, busB.node_count);
    end
    rstA = 1'b0;
    rstB = 1'b0;
    cycle();
    total++;
    if (busA.load_ready !== 1'b1 || busB.load_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ready_rise: got %b/%b want 1/1", busA.load_ready, busB.load_ready);
    end
    nA      = 0;
    reloadA = 1'b0;
  endtask

  task automatic test_small_count();
    busA.start = 1'b1;
    cycle();
    busA.start = 1'b0;
    total++;
    if ({busA.done, busA.count_error, busA.busy, busA.batch_valid} !== {1'b1, 1'b1, 1'b0, 4'b0}) begin
      bad++;
      $display("[TB] FAIL n0_start: got done=%b err=%b busy=%b v=%b want 1 1 0 0000", busA.done, busA.count_error, busA.busy, busA.batch_valid);
    end
    cycle();
    total++;
    if ({busA.done, busA.count_error, busA.batch_valid} !== {1'b0, 1'b1, 4'b0}) begin
      bad++;
      $display("[TB] FAIL n0_after: got done=%b err=%b v=%b want 0 1 0000", busA.done, busA.count_error, busA.batch_valid);
    end
    load_a();
    total++;
    if (busA.count_error !== 1'b0 || busA.node_count !== (A_IW+1)'(nA)) begin
      bad++;
      $display("[TB] FAIL n1_load_clears_err: got err=%b count=%0d want 0 %0d", busA.count_error, busA.node_count, nA);
    end
    busA.start = 1'b1;
    cycle();
    busA.start = 1'b0;
    total++;
    if ({busA.done, busA.count_error, busA.busy, busA.batch_valid} !== {1'b1, 1'b1, 1'b0, 4'b0}) begin
      bad++;
      $display("[TB] FAIL n1_start: got done=%b err=%b busy=%b v=%b want 1 1 0 0000", busA.done, busA.count_error, busA.busy, busA.batch_valid);
    end
    cycle();
    repeat (4) load_a();
    total++;
    if (busA.count_error !== 1'b0 || busA.node_count !== (A_IW+1)'(nA)) begin
      bad++;
      $display("[TB] FAIL n5_loaded: got err=%b count=%0d want 0 %0d", busA.count_error, busA.node_count, nA);
    end
  endtask

  task automatic test_basic_run(input string tag);
    build_expected(nA, A_B);
    busA.out_ready = 1'b1;
    busA.start     = 1'b1;
    cycle();
    busA.start = 1'b0;
    total++;
    if (busA.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_busy_rise: got %b want 1", tag, busA.busy);
    end
    for (int p = 0; p < qJ.size(); p++) begin
      observe_a();
      expect_beat_a(qI[p], qJ[p], nA);
      total++;
      if ({obsValA, obsIdxA, obsCrdA, obsLeA, obsSeA} !== {expValA, expIdxA, expCrdA, expLeA, expSeA}) begin
        bad++;
        $display("[TB] FAIL %s_beat%0d: got v=%b idx=%h le=%b se=%b crd=%h want v=%b idx=%h le=%b se=%b crd=%h",
                 tag, p, obsValA, obsIdxA, obsLeA, obsSeA, obsCrdA, expValA, expIdxA, expLeA, expSeA, expCrdA);
      end
      cycle();
    end
    total++;
    if ({busA.done, busA.busy, busA.batch_valid} !== {1'b1, 1'b0, 4'b0}) begin
      bad++;
      $display("[TB] FAIL %s_done_pulse: got done=%b busy=%b v=%b want 1 0 0000", tag, busA.done, busA.busy, busA.batch_valid);
    end
    reloadA = 1'b1;
    cycle();
    total++;
    if (busA.done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_done_width: got %b want 0", tag, busA.done);
    end
  endtask

  task automatic test_back_to_back();
    test_basic_run("rerun");
  endtask

  task automatic test_backpressure();
    int  p;
    int  n;
    bit  seenDone;
    bit  rdy;
    build_expected(nA, A_B);
    n        = qJ.size();
    p        = 0;
    seenDone = 1'b0;
    busA.out_ready = 1'b0;
    busA.start     = 1'b1;
    cycle();
    busA.start = 1'b0;
    for (int cyc = 0; cyc < 200 && !seenDone; cyc++) begin
      if (busA.done) begin
        seenDone = 1'b1;
      end else if (p >= n) begin
        total++;
        bad++;
        $display("[TB] FAIL bp_extra_beat: got v=%b after %0d accepts want done", busA.batch_valid, p);
        break;
      end else begin
        observe_a();
        expect_beat_a(qI[p], qJ[p], nA);
        total++;
        if ({obsValA, obsIdxA, obsCrdA, obsLeA, obsSeA} !== {expValA, expIdxA, expCrdA, expLeA, expSeA}) begin
          bad++;
          $display("[TB] FAIL bp_beat%0d_cyc%0d: got v=%b idx=%h le=%b se=%b want v=%b idx=%h le=%b se=%b",
                   p, cyc, obsValA, obsIdxA, obsLeA, obsSeA, expValA, expIdxA, expLeA, expSeA);
        end
        rdy = ($urandom_range(0, 2) != 0);
        busA.out_ready = rdy;
        cycle();
        if (rdy) p++;
      end
    end
    total++;
    if (seenDone !== 1'b1 || p != n) begin
      bad++;
      $display("[TB] FAIL bp_accept_count: got done=%b accepted=%0d want 1 %0d", seenDone, p, n);
    end
    busA.out_ready = 1'b1;
    reloadA = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid_emit();
    busA.out_ready = 1'b1;
    busA.start     = 1'b1;
    cycle();
    busA.start = 1'b0;
    cycle();
    rstA = 1'b1;
    cycle();
    rstA = 1'b0;
    total++;
    if ({busA.batch_valid, busA.busy, busA.done} !== {4'b0, 1'b0, 1'b0} || busA.node_count !== '0) begin
      bad++;
      $display("[TB] FAIL mid_reset: got v=%b busy=%b done=%b count=%0d want 0000 0 0 0",
               busA.batch_valid, busA.busy, busA.done, busA.node_count);
    end
    nA      = 0;
    reloadA = 1'b0;
    cycle();
    total++;
    if (busA.load_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_reset_ready: got %b want 1", busA.load_ready);
    end
  endtask

  task automatic test_reload();
    repeat (5) load_a();
    total++;
    if (busA.node_count !== (A_IW+1)'(nA)) begin
      bad++;
      $display("[TB] FAIL reload_fill: got %0d want %0d", busA.node_count, nA);
    end
    test_basic_run("reload_first");
    load_a();
    total++;
    if (busA.node_count !== (A_IW+1)'(1)) begin
      bad++;
      $display("[TB] FAIL reload_count: got %0d want 1", busA.node_count);
    end
    repeat (4) load_a();
    test_basic_run("reload_second");
  endtask

  task automatic test_full_storage();
    int   beats;
    int   seCount;
    int   expBeats;
    int   j0;
    int   i;
    bit   lastSe;
    bit   seenDone;
    bit   exLe;
    logic [B_B-1:0] ev;
    for (int k = 0; k < B_MAX; k++) begin
      if (k == 0 || k == B_MAX - 1) begin
        total++;
        if (busB.load_ready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL full_ready_before%0d: got %b want 1", k, busB.load_ready);
        end
      end
      busB.load_valid = 1'b1;
      for (int d = 0; d < D; d++) begin
        mB[k][d]           = int'($urandom_range(0, (1 << C) - 1));
        busB.load_coord[d] = C'(mB[k][d]);
      end
      cycle();
    end
    busB.load_valid = 1'b0;
    total++;
    if (busB.load_ready !== 1'b0 || busB.node_count !== (B_IW+1)'(B_MAX)) begin
      bad++;
      $display("[TB] FAIL full_ready_drop: got ready=%b count=%0d want 0 %0d", busB.load_ready, busB.node_count, B_MAX);
    end
    busB.load_valid = 1'b1;
    cycle();
    busB.load_valid = 1'b0;
    total++;
    if (busB.node_count !== (B_IW+1)'(B_MAX)) begin
      bad++;
      $display("[TB] FAIL full_overflow_ignored: got %0d want %0d", busB.node_count, B_MAX);
    end
    build_expected(B_MAX, B_B);
    expBeats = 0;
    for (int r = 0; r <= B_MAX - 2; r++) expBeats += (B_MAX - r + B_B - 1) / B_B;
    beats    = 0;
    seCount  = 0;
    lastSe   = 1'b0;
    seenDone = 1'b0;
    busB.out_ready = 1'b1;
    busB.start     = 1'b1;
    cycle();
    busB.start = 1'b0;
    for (int cyc = 0; cyc < 400 && !seenDone; cyc++) begin
      if (busB.done) begin
        seenDone = 1'b1;
      end else begin
        if (|busB.batch_valid) begin
          if (beats < qJ.size()) begin
            j0   = qJ[beats];
            i    = qI[beats];
            for (int k = 0; k < B_B; k++) ev[k] = (j0 + k < B_MAX);
            exLe = (j0 + B_B >= B_MAX);
            total++;
            if ({busB.batch_valid, busB.batch_indices[0], busB.batch_coords[0][0], busB.batch_coords[0][1],
                 busB.batch_coords[0][2], busB.batch_line_end, busB.batch_stream_end} !==
                {ev, B_IW'(j0), C'(mB[j0][0]), C'(mB[j0][1]), C'(mB[j0][2]), exLe, exLe && (i == B_MAX - 2)}) begin
              bad++;
              $display("[TB] FAIL full_beat%0d: got v=%h idx0=%0d le=%b se=%b want v=%h idx0=%0d le=%b se=%b",
                       beats, busB.batch_valid, busB.batch_indices[0], busB.batch_line_end, busB.batch_stream_end,
                       ev, j0, exLe, exLe && (i == B_MAX - 2));
            end
          end
          if (busB.batch_stream_end) seCount++;
          lastSe = busB.batch_stream_end;
          beats++;
        end
        cycle();
      end
    end
    total++;
    if (seenDone !== 1'b1 || beats != expBeats) begin
      bad++;
      $display("[TB] FAIL full_beat_count: got done=%b beats=%0d want 1 %0d", seenDone, beats, expBeats);
    end
    total++;
    if (seCount != 1 || lastSe !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_stream_end: got count=%0d last=%b want 1 1", seCount, lastSe);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    test_reset();
    test_small_count();
    test_basic_run("n5");
    test_back_to_back();
    test_backpressure();
    test_reset_mid_emit();
    test_reload();
    test_full_storage();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
